mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one single-ported memory bus between the IF fetch port and the MEM-stage
//   data port. Latches and serialises requests, tolerates bus wait states, and
//   returns read data with a one-cycle ready pulse. Raises stall_req_o to pipeline
//   control while a requester waits. Data port has fixed priority over fetch.
// PARAMETERS
//   DATA_W          32   bus data width
//   ADDR_W          32   bus address width
//   TIMEOUT_CYCLES  255  cycles without bus_ack_i before abort (MEM_ARB_TIMEOUT_EN only)
//   CNT_W           8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst          in   1       reset, synchronous, active-low
//   if_ce_i      in   1       fetch request; held until if_ready_o
//   if_addr_i    in   ADDR_W  fetch address
//   if_data_o    out  DATA_W  fetched word; valid with if_ready_o
//   if_ready_o   out  1       one-cycle fetch-complete pulse
//   mem_ce_i     in   1       data request; held until mem_ready_o
//   mem_we_i     in   1       1 = store
//   mem_sel_i    in   4       byte enables; 4'b0000 = suppressed (misaligned) access
//   mem_addr_i   in   ADDR_W  data address
//   mem_data_i   in   DATA_W  store data
//   mem_data_o   out  DATA_W  load data; valid with mem_ready_o
//   mem_ready_o  out  1       one-cycle data-complete pulse
//   flush_i      in   1       pipeline flush; discards an in-flight fetch result
//   bus_req_o    out  1       bus cycle active; held until bus_ack_i
//   bus_we_o     out  1       bus write enable
//   bus_sel_o    out  4       bus byte enables
//   bus_addr_o   out  ADDR_W  bus address
//   bus_wdata_o  out  DATA_W  bus write data
//   bus_rdata_i  in   DATA_W  bus read data; sampled when bus_ack_i=1
//   bus_ack_i    in   1       bus cycle complete
//   stall_req_o  out  1       comb: (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o)
//   bus_err_o    out  1       one-cycle timeout pulse
// BEHAVIOUR
//   - Reset (rst=0 at a clk edge): state IDLE. All registered outputs = 0; cnt = 0.
//     An in-flight bus cycle is abandoned: bus_req_o = 0 on the next cycle.
//   - States: IDLE, D_BUSY, I_BUSY, DONE.
//   - IDLE, mem_ce_i=1, mem_sel_i!=0 -> latch we/sel/addr/wdata onto bus_*_o; bus_req_o=1; go D_BUSY.
//   - IDLE, mem_ce_i=1, mem_sel_i==0 -> no bus cycle; mem_data_o=0; mem_ready_o=1 next cycle; go DONE.
//   - IDLE, mem_ce_i=0, if_ce_i=1 -> bus_we_o=0, bus_sel_o=4'b1111, bus_addr_o=if_addr_i; go I_BUSY.
//   - Both ce high in IDLE: data wins; fetch waits (stall already held by the data port).
//   - D_BUSY/I_BUSY: bus_* outputs stable; requester-port input changes are ignored.
//     On bus_ack_i: bus_req_o=0, capture bus_rdata_i into mem_data_o/if_data_o,
//     pulse the matching ready next cycle, go DONE.
//   - DONE: one cycle, no new grant (the requester deasserts or updates its ce); go IDLE.
//   - Latency, zero-wait bus: req at cycle 0, bus_req_o cycle 1, ack cycle 1, ready cycle 2,
//     next grant evaluated cycle 3. Each bus wait state adds one cycle.
//   - Store: mem_ready_o pulses; mem_data_o is not updated.
//   - flush_i=1 in I_BUSY: bus cycle runs to ack (no bus abort), then if_ready_o is held 0
//     and the data is discarded. flush_i=1 in IDLE/DONE: no effect on pending data-port work.
//     flush_i has no effect on D_BUSY.
//   - Ready pulses are exactly 1 cycle; if_data_o/mem_data_o hold until the next capture.
// CONFIGURATION
//   MEM_ARB_TIMEOUT_EN defined: cnt counts cycles in D_BUSY/I_BUSY (cleared on entry).
//     At cnt==TIMEOUT_CYCLES with no ack: bus_req_o=0, bus_err_o pulses 1 cycle,
//     requester data=0, ready pulses, go DONE. An ack in the same cycle as the limit
//     wins (normal completion, no error).
//   Not defined: no counter; waits indefinitely for ack; bus_err_o tied 0.
// TESTING
//   1 LW, bus ack 0 wait: mem_ce_i=1, addr=0x100, sel=4'hF, rdata=0x12345678
//     -> bus_req_o cycle 1, mem_ready_o cycle 2, mem_data_o=0x12345678, stall_req_o low cycle 2.
//   2 Contention: if_ce_i=1 and mem_ce_i=1 (SW 0xA5A5A5A5 to 0x200) in the same cycle
//     -> write issued first; fetch bus_req_o only after DONE; stall_req_o high throughout.
//   3 Wait states: ack delayed 3 cycles -> bus_* held stable, if_ready_o at cycle 5.
//   4 mem_sel_i=0 with mem_ce_i=1 -> no bus_req_o; mem_ready_o next cycle, mem_data_o=0.
//   5 flush_i=1 during I_BUSY -> ack consumed, if_ready_o never pulses; rst=0 mid-D_BUSY
//     -> bus_req_o=0 next cycle, state IDLE.
//   6 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_o and mem_ready_o pulse
//     with data 0; same run without the macro -> stall held indefinitely, bus_err_o=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-ported memory bus between the instruction-fetch port and
//   the MEM-stage data port. A request is latched onto the bus and held there
//   until bus_ack_i arrives. The read data is then returned together with a
//   one-cycle ready pulse. The data port has fixed priority over fetch.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort a bus cycle after
//   TIMEOUT_CYCLES cycles without an ack. An abort pulses bus_err_o, returns
//   zero data and still completes the request. Without the macro the arbiter
//   waits for an ack indefinitely and bus_err_o is tied low.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   if_ce_i / if_addr_i      fetch request, held until if_ready_o
//   if_data_o / if_ready_o   fetched word and its one-cycle completion pulse
//   mem_ce_i/we/sel/addr/data data request, held until mem_ready_o
//                            (sel == 0 marks a suppressed misaligned access)
//   mem_data_o / mem_ready_o load data and its one-cycle completion pulse
//   flush_i                  discards the result of an in-flight fetch
//   bus_*_o / bus_*_i        single-ported memory bus (req held until ack)
//   stall_req_o              a requester is still waiting for completion
//   bus_err_o                one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ready_o,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stall_req_o,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, DONE} state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e              state_q;
    logic                flush_q;     // flush seen during the current fetch
    logic [DATA_W-1:0]   if_data_q;
    logic                if_ready_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic                mem_ready_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [3:0]          bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                bus_err_q;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]    cnt_q;
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_LIMIT;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            if_data_q   <= '0;
            if_ready_q  <= 1'b0;
            mem_data_q  <= '0;
            mem_ready_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'b0000;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            // Completion pulses last one cycle unless re-raised below.
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    flush_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    if (mem_ce_i) begin
                        if (mem_sel_i != 4'b0000) begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_we_i;
                            bus_sel_q   <= mem_sel_i;
                            bus_addr_q  <= mem_addr_i;
                            bus_wdata_q <= mem_data_i;
                            state_q     <= D_BUSY;
                        end else begin
                            // Suppressed access: complete locally with zero data.
                            mem_data_q  <= '0;
                            mem_ready_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else if (if_ce_i) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_sel_q   <= 4'b1111;
                        bus_addr_q  <= if_addr_i;
                        bus_wdata_q <= '0;
                        state_q     <= I_BUSY;
                    end
                end

                D_BUSY, I_BUSY: begin
                    // A flush never aborts the bus cycle; it only drops the result.
                    if (state_q == I_BUSY && flush_i) flush_q <= 1'b1;
                    if (bus_ack_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (state_q == D_BUSY) begin
                            mem_ready_q <= 1'b1;
                            if (!bus_we_q) mem_data_q <= bus_rdata_i;
                        end else if (!(flush_q || flush_i)) begin
                            if_data_q  <= bus_rdata_i;
                            if_ready_q <= 1'b1;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // An ack in the limit cycle takes the branch above instead.
                    else if (cnt_q == TIMEOUT_LIMIT) begin
                        bus_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                        if (state_q == D_BUSY) begin
                            mem_data_q  <= '0;
                            mem_ready_q <= 1'b1;
                        end else if (!(flush_q || flush_i)) begin
                            if_data_q  <= '0;
                            if_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end

                // One dead cycle lets the requester drop or update its ce.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_data_o   = if_data_q;
    assign if_ready_o  = if_ready_q;
    assign mem_data_o  = mem_data_q;
    assign mem_ready_o = mem_ready_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_err_o   = bus_err_q;

    // NOTE: stall is a pure continuous assign of current inputs/outputs, so no
    // storage element (latch) can be inferred for it.
    assign stall_req_o = (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter. Each scenario task drives the
//   ports one cycle at a time (inputs change 1 time unit after a rising edge,
//   outputs are sampled at that same point). Expected read data is pushed onto
//   a scoreboard queue when a request is issued. It is popped and compared
//   when the matching ready pulse appears. The timeout scenario follows
//   MEM_ARB_TIMEOUT_EN, with TIMEOUT_CYCLES overridden to 4.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stall_req_o;
    logic        bus_err_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_exp_q[$];
    logic [31:0] if_exp_q[$];
    logic [31:0] exp_v;

    mem_bus_arbiter #(
        .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
        .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_req_o(stall_req_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pops; an empty queue yields X so the comparison fails.
    function automatic logic [31:0] pop_mem();
        if (mem_exp_q.size() == 0) return 'x;
        return mem_exp_q.pop_front();
    endfunction

    function automatic logic [31:0] pop_if();
        if (if_exp_q.size() == 0) return 'x;
        return if_exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b0; if_ce_i = 1'b0; if_addr_i = '0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
        mem_sel_i = 4'h0; mem_addr_i = '0; mem_data_i = '0; flush_i = 1'b0;
        bus_rdata_i = '0; bus_ack_i = 1'b0;
        tick(); tick();
        checks++; if ({bus_req_o, mem_ready_o, if_ready_o, bus_err_o, stall_req_o} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl act=%b exp=00000",
                {bus_req_o, mem_ready_o, if_ready_o, bus_err_o, stall_req_o}); end
        checks++; if (mem_data_o !== 32'h0 || if_data_o !== 32'h0) begin
            failures++; $display("FAIL reset_data act=%h/%h exp=0/0", mem_data_o, if_data_o); end
        checks++; if (bus_sel_o !== 4'h0 || bus_addr_o !== 32'h0 || bus_we_o !== 1'b0) begin
            failures++; $display("FAIL reset_bus act=%h/%h/%b exp=0", bus_sel_o, bus_addr_o, bus_we_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        // cycle 0: issue the load
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h100;
        mem_exp_q.push_back(32'h12345678);
        tick(); // cycle 1
        checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF) begin
            failures++; $display("FAIL lw_bus act=req%b addr%h we%b sel%h exp=req1 addr100 we0 self",
                bus_req_o, bus_addr_o, bus_we_o, bus_sel_o); end
        checks++; if (stall_req_o !== 1'b1 || mem_ready_o !== 1'b0) begin
            failures++; $display("FAIL lw_wait act=stall%b rdy%b exp=stall1 rdy0", stall_req_o, mem_ready_o); end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
        flush_i = 1'b1; // must not disturb a data-port cycle
        tick(); // cycle 2
        bus_ack_i = 1'b0; flush_i = 1'b0;
        checks++; if (mem_ready_o !== 1'b1) begin
            failures++; $display("FAIL lw_ready act=%b exp=1", mem_ready_o); end
        exp_v = pop_mem();
        checks++; if (mem_data_o !== exp_v) begin
            failures++; $display("FAIL lw_data act=%h exp=%h", mem_data_o, exp_v); end
        checks++; if (stall_req_o !== 1'b0 || bus_req_o !== 1'b0) begin
            failures++; $display("FAIL lw_done act=stall%b req%b exp=0/0", stall_req_o, bus_req_o); end
        mem_ce_i = 1'b0;
        tick(); // cycle 3
        checks++; if (mem_ready_o !== 1'b0 || mem_data_o !== 32'h12345678) begin
            failures++; $display("FAIL lw_pulse act=rdy%b data%h exp=rdy0 data12345678", mem_ready_o, mem_data_o); end
    endtask

    task automatic test_contention();
        // cycle 0: both ports request; the store must win
        if_ce_i = 1'b1; if_addr_i = 32'h40;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h200; mem_data_i = 32'hA5A5A5A5;
        if_exp_q.push_back(32'hCAFEF00D);
        tick(); // cycle 1
        checks++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h200 || bus_wdata_o !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL cont_store act=req%b we%b addr%h wd%h exp=1/1/200/a5a5a5a5",
                bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o); end
        checks++; if (stall_req_o !== 1'b1) begin
            failures++; $display("FAIL cont_stall1 act=%b exp=1", stall_req_o); end
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF0000;
        tick(); // cycle 2
        bus_ack_i = 1'b0;
        checks++; if (mem_ready_o !== 1'b1 || mem_data_o !== 32'h12345678) begin
            failures++; $display("FAIL cont_store_done act=rdy%b data%h exp=rdy1 data12345678", mem_ready_o, mem_data_o); end
        checks++; if (stall_req_o !== 1'b1 || bus_req_o !== 1'b0) begin
            failures++; $display("FAIL cont_stall2 act=stall%b req%b exp=1/0", stall_req_o, bus_req_o); end
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        tick(); // cycle 3: IDLE grants the fetch
        checks++; if (bus_req_o !== 1'b0 || stall_req_o !== 1'b1) begin
            failures++; $display("FAIL cont_gap act=req%b stall%b exp=0/1", bus_req_o, stall_req_o); end
        tick(); // cycle 4
        checks++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF || bus_addr_o !== 32'h40) begin
            failures++; $display("FAIL cont_fetch act=req%b we%b sel%h addr%h exp=1/0/f/40",
                bus_req_o, bus_we_o, bus_sel_o, bus_addr_o); end
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        tick(); // cycle 5
        bus_ack_i = 1'b0;
        exp_v = pop_if();
        checks++; if (if_ready_o !== 1'b1 || if_data_o !== exp_v) begin
            failures++; $display("FAIL cont_fetch_data act=rdy%b data%h exp=rdy1 data%h", if_ready_o, if_data_o, exp_v); end
        if_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h500;
`ifdef MEM_ARB_TIMEOUT_EN
        mem_exp_q.push_back(32'h0);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            tick(); n++;
            if (mem_ready_o) got = 1'b1;
            else begin
                checks++; if (bus_req_o !== 1'b1 || bus_err_o !== 1'b0) begin
                    failures++; $display("FAIL to_wait c=%0d act=req%b err%b exp=1/0", n, bus_req_o, bus_err_o); end
            end
        end
        checks++; if (n !== 6) begin
            failures++; $display("FAIL to_latency act=%0d exp=6", n); end
        checks++; if (bus_err_o !== 1'b1 || bus_req_o !== 1'b0) begin
            failures++; $display("FAIL to_err act=err%b req%b exp=1/0", bus_err_o, bus_req_o); end
        exp_v = pop_mem();
        checks++; if (mem_data_o !== exp_v) begin
            failures++; $display("FAIL to_data act=%h exp=%h", mem_data_o, exp_v); end
        mem_ce_i = 1'b0;
        tick();
        checks++; if (bus_err_o !== 1'b0 || mem_ready_o !== 1'b0) begin
            failures++; $display("FAIL to_pulse act=err%b rdy%b exp=0/0", bus_err_o, mem_ready_o); end
`else
        mem_exp_q.push_back(32'h77778888);
        for (int c = 1; c <= 30; c++) begin
            tick();
            checks++; if (bus_req_o !== 1'b1 || stall_req_o !== 1'b1 || bus_err_o !== 1'b0 || mem_ready_o !== 1'b0) begin
                failures++; $display("FAIL nto_hold c=%0d act=req%b stall%b err%b rdy%b exp=1/1/0/0",
                    c, bus_req_o, stall_req_o, bus_err_o, mem_ready_o); end
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h77778888;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            tick(); n++;
            bus_ack_i = 1'b0;
            if (mem_ready_o) got = 1'b1;
        end
        exp_v = pop_mem();
        checks++; if (n !== 1 || mem_data_o !== exp_v) begin
            failures++; $display("FAIL nto_late_ack act=cyc%0d data%h exp=cyc1 data%h", n, mem_data_o, exp_v); end
        mem_ce_i = 1'b0;
        tick();
`endif
    endtask

    task automatic test_wait_states();
        int n;
        bit got;
        if_ce_i = 1'b1; if_addr_i = 32'h80;
        if_exp_q.push_back(32'h0BADBEEF);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h80 || bus_sel_o !== 4'hF || bus_we_o !== 1'b0) begin
                failures++; $display("FAIL ws_hold c=%0d act=req%b addr%h sel%h we%b exp=1/80/f/0",
                    c, bus_req_o, bus_addr_o, bus_sel_o, bus_we_o); end
            if_addr_i = 32'h900 + 32'(c); // port changes while busy are ignored
            if (c == 4) begin bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADBEEF; end
        end
        n = 4; got = 1'b0;
        while (!got && n < 16) begin
            tick(); n++;
            bus_ack_i = 1'b0;
            if (if_ready_o) got = 1'b1;
        end
        checks++; if (n !== 5) begin
            failures++; $display("FAIL ws_ready_cycle act=%0d exp=5", n); end
        exp_v = pop_if();
        checks++; if (if_data_o !== exp_v) begin
            failures++; $display("FAIL ws_data act=%h exp=%h", if_data_o, exp_v); end
        if_ce_i = 1'b0;
        tick();
        checks++; if (if_ready_o !== 1'b0) begin
            failures++; $display("FAIL ws_pulse act=%b exp=0", if_ready_o); end
    endtask

    task automatic test_suppressed();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h301;
        mem_exp_q.push_back(32'h0);
        tick(); // cycle 1
        exp_v = pop_mem();
        checks++; if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b1 || mem_data_o !== exp_v) begin
            failures++; $display("FAIL sup_done act=req%b rdy%b data%h exp=0/1/%h", bus_req_o, mem_ready_o, mem_data_o, exp_v); end
        mem_ce_i = 1'b0;
        tick(); // cycle 2
        checks++; if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b0) begin
            failures++; $display("FAIL sup_after act=req%b rdy%b exp=0/0", bus_req_o, mem_ready_o); end
        tick();
    endtask

    task automatic test_flush();
        int pulses;
        if_ce_i = 1'b1; if_addr_i = 32'hC0;
        tick(); // cycle 1
        flush_i = 1'b1;
        tick(); // cycle 2: flush must not abort the bus cycle
        flush_i = 1'b0;
        checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'hC0) begin
            failures++; $display("FAIL fl_no_abort act=req%b addr%h exp=1/c0", bus_req_o, bus_addr_o); end
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADDEAD;
        tick(); // cycle 3
        bus_ack_i = 1'b0;
        checks++; if (bus_req_o !== 1'b0) begin
            failures++; $display("FAIL fl_ack_taken act=%b exp=0", bus_req_o); end
        pulses = int'(if_ready_o);
        if_ce_i = 1'b0;
        for (int c = 0; c < 3; c++) begin tick(); pulses += int'(if_ready_o); end
        checks++; if (pulses !== 0) begin
            failures++; $display("FAIL fl_no_ready act=%0d pulses exp=0", pulses); end
        checks++; if (if_data_o !== 32'h0BADBEEF) begin
            failures++; $display("FAIL fl_data_kept act=%h exp=0badbeef", if_data_o); end
    endtask

    task automatic test_reset_mid();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h400;
        tick(); // cycle 1: D_BUSY
        checks++; if (bus_req_o !== 1'b1) begin
            failures++; $display("FAIL rm_busy act=%b exp=1", bus_req_o); end
        rst = 1'b0; mem_ce_i = 1'b0;
        tick(); // cycle 2: reset applied
        checks++; if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b0 || mem_data_o !== 32'h0 || if_data_o !== 32'h0) begin
            failures++; $display("FAIL rm_clear act=req%b rdy%b md%h id%h exp=0/0/0/0",
                bus_req_o, mem_ready_o, mem_data_o, if_data_o); end
        rst = 1'b1;
        if_ce_i = 1'b1; if_addr_i = 32'h44;
        if_exp_q.push_back(32'h13579BDF);
        tick(); // cycle 3: IDLE again, so the fetch is granted
        checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h44) begin
            failures++; $display("FAIL rm_idle act=req%b addr%h exp=1/44", bus_req_o, bus_addr_o); end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h13579BDF;
        tick();
        bus_ack_i = 1'b0;
        exp_v = pop_if();
        checks++; if (if_ready_o !== 1'b1 || if_data_o !== exp_v) begin
            failures++; $display("FAIL rm_fetch act=rdy%b data%h exp=1/%h", if_ready_o, if_data_o, exp_v); end
        if_ce_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_contention();
        test_timeout();
        test_wait_states();
        test_suppressed();
        test_flush();
        test_reset_mid();
        checks++; if (mem_exp_q.size() != 0 || if_exp_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover act=%0d/%0d exp=0/0", mem_exp_q.size(), if_exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
